// File: rtl/apu_master_pkg.sv
// Shared types for the APU request/response initiator: tag lifecycle states,
// default geometry and the response-buffer entry layout.
package apu_master_pkg;

  localparam int unsigned DEF_NB_OUTSTANDING  = 4;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_FLAGS_OUT_WIDTH = 5;

  function automatic int unsigned tag_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  localparam int unsigned DEF_TAG_W = tag_width(DEF_NB_OUTSTANDING);

  typedef enum logic [1:0] {
    TAG_FREE   = 2'd0,
    TAG_ISSUED = 2'd1,
    TAG_DONE   = 2'd2
  } tag_state_e;

  // Entry layout for the default geometry; the top builds its own from its parameters.
  typedef struct packed {
    logic [DEF_TAG_W-1:0]           tag;
    logic [DEF_DATA_WIDTH-1:0]      data;
    logic [DEF_FLAGS_OUT_WIDTH-1:0] flags;
  } resp_entry_t;

endpackage

// File: rtl/apu_resp_fifo.sv
// Synchronous FIFO buffering accepted APU responses until the core takes them.
module apu_resp_fifo
  import apu_master_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_NB_OUTSTANDING,
  parameter type         entry_t = resp_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/apu_master_issue.sv
// Core-side APU initiator: tags requests, holds them until granted, and returns
// possibly out-of-order responses to the core together with the caller context.
module apu_master_issue
  import apu_master_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = 9,
  parameter int unsigned NB_ARGS         = 2,
  parameter int unsigned OPCODE_WIDTH    = 6,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FLAGS_IN_WIDTH  = 15,
  parameter int unsigned FLAGS_OUT_WIDTH = 5,
  parameter int unsigned CTX_WIDTH       = 5,
  parameter int unsigned NB_OUTSTANDING  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] req_operands_i,
  input  logic [OPCODE_WIDTH-1:0]       req_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]     req_flags_i,
  input  logic [CTX_WIDTH-1:0]          req_ctx_i,
  output logic                          apu_req_o,
  input  logic                          apu_gnt_i,
  output logic [ID_WIDTH-1:0]           apu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o,
  output logic [OPCODE_WIDTH-1:0]       apu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o,
  output logic                          apu_rready_o,
  input  logic                          apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         apu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i,
  input  logic [ID_WIDTH-1:0]           apu_rID_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [DATA_WIDTH-1:0]         res_data_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    res_flags_o,
  output logic [CTX_WIDTH-1:0]          res_ctx_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned TAG_W = tag_width(NB_OUTSTANDING);
  localparam int unsigned OPS_W = NB_ARGS * DATA_WIDTH;

  if (ID_WIDTH < TAG_W) begin : g_id_width_check
    $error("ID_WIDTH must be at least the tag width");
  end
  if (NB_OUTSTANDING < 2 || (NB_OUTSTANDING & (NB_OUTSTANDING - 1)) != 0) begin : g_nb_check
    $error("NB_OUTSTANDING must be a power of two >= 2");
  end

  typedef struct packed {
    logic [TAG_W-1:0]           tag;
    logic [DATA_WIDTH-1:0]      data;
    logic [FLAGS_OUT_WIDTH-1:0] flags;
  } entry_t;

  tag_state_e                 tag_state_q [NB_OUTSTANDING];
  tag_state_e                 tag_state_d [NB_OUTSTANDING];
  logic [CTX_WIDTH-1:0]       ctx_table_q [NB_OUTSTANDING];
  logic                       hold_valid_q, hold_valid_d;
  logic [TAG_W-1:0]           hold_tag_q, hold_tag_d;
  logic [OPS_W-1:0]           hold_ops_q, hold_ops_d;
  logic [OPCODE_WIDTH-1:0]    hold_op_q, hold_op_d;
  logic [FLAGS_IN_WIDTH-1:0]  hold_flags_q, hold_flags_d;
  logic                       err_q;

  logic                       any_free;
  logic [TAG_W-1:0]           alloc_tag;
  logic                       accept, grant, pop, rsp_ok;
  logic [TAG_W-1:0]           rsp_tag;
  logic                       fifo_full, fifo_empty;
  entry_t                     push_entry, head;

  // Lowest-index FREE tag, taken from registered state only.
  always_comb begin
    any_free  = 1'b0;
    alloc_tag = '0;
    for (int unsigned i = 0; i < NB_OUTSTANDING; i++) begin
      if (!any_free && tag_state_q[i] == TAG_FREE) begin
        any_free  = 1'b1;
        alloc_tag = TAG_W'(i);
      end
    end
  end

  assign req_ready_o = (!hold_valid_q || apu_gnt_i) && any_free;
  assign accept      = req_valid_i && req_ready_o;
  assign grant       = hold_valid_q && apu_gnt_i;

  assign rsp_tag     = apu_rID_i[TAG_W-1:0];
  assign rsp_ok      = apu_rvalid_i && ((apu_rID_i >> TAG_W) == '0)
                       && (tag_state_q[rsp_tag] == TAG_ISSUED);
  assign push_entry  = '{tag: rsp_tag, data: apu_rdata_i, flags: apu_rflags_i};
  assign pop         = !fifo_empty && res_ready_i;

  // Transitions are disjoint: each applies to a tag in a different current state.
  always_comb begin
    tag_state_d = tag_state_q;
    for (int unsigned i = 0; i < NB_OUTSTANDING; i++) begin
      if (accept && alloc_tag == TAG_W'(i)) tag_state_d[i] = TAG_ISSUED;
      if (rsp_ok && rsp_tag == TAG_W'(i))   tag_state_d[i] = TAG_DONE;
      if (pop && head.tag == TAG_W'(i))     tag_state_d[i] = TAG_FREE;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_tag_d   = hold_tag_q;
    hold_ops_d   = hold_ops_q;
    hold_op_d    = hold_op_q;
    hold_flags_d = hold_flags_q;
    if (grant) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_tag_d   = alloc_tag;
      hold_ops_d   = req_operands_i;
      hold_op_d    = req_op_i;
      hold_flags_d = req_flags_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_tag_q   <= '0;
      hold_ops_q   <= '0;
      hold_op_q    <= '0;
      hold_flags_q <= '0;
      err_q        <= 1'b0;
      for (int unsigned i = 0; i < NB_OUTSTANDING; i++) begin
        tag_state_q[i] <= TAG_FREE;
        ctx_table_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_ops_q   <= hold_ops_d;
      hold_op_q    <= hold_op_d;
      hold_flags_q <= hold_flags_d;
      err_q        <= apu_rvalid_i && !rsp_ok;
      tag_state_q  <= tag_state_d;
      if (accept) ctx_table_q[alloc_tag] <= req_ctx_i;
    end
  end

  apu_resp_fifo #(
    .DEPTH   (NB_OUTSTANDING),
    .entry_t (entry_t)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_ok),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic busy_tags;
  always_comb begin
    busy_tags = 1'b0;
    for (int unsigned i = 0; i < NB_OUTSTANDING; i++)
      if (tag_state_q[i] != TAG_FREE) busy_tags = 1'b1;
  end

  assign apu_req_o      = hold_valid_q;
  assign apu_ID_o       = ID_WIDTH'(hold_tag_q);
  assign apu_operands_o = hold_ops_q;
  assign apu_op_o       = hold_op_q;
  assign apu_flags_o    = hold_flags_q;
  assign apu_rready_o   = 1'b1;
  assign res_valid_o    = !fifo_empty;
  assign res_data_o     = head.data;
  assign res_flags_o    = head.flags;
  assign res_ctx_o      = ctx_table_q[head.tag];
  assign busy_o         = busy_tags || hold_valid_q;
  assign err_o          = err_q;

endmodule
